// File: rtl/seg7_scan_if.sv
// Bundle between the hex decoder (master) and the 4-digit scanner (slave).
// The bright field exists only when SEG7_BRIGHTNESS_EN is defined.
interface seg7_scan_if;
  logic [27:0] D_in;
  logic [3:0]  AN_in;
`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0]  bright;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_start;

`ifdef SEG7_BRIGHTNESS_EN
  modport master (output D_in, AN_in, bright, input  seg, an, frame_start);
  modport slave  (input  D_in, AN_in, bright, output seg, an, frame_start);
`else
  modport master (output D_in, AN_in, input  seg, an, frame_start);
  modport slave  (input  D_in, AN_in, output seg, an, frame_start);
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// Frame-coherent 4-digit 7-segment scanner with guard blanking between digits.
// Optional PWM dimming via the bright field when SEG7_BRIGHTNESS_EN is defined.
module seg7_scan_driver #(
  parameter int DIV_W = 16,
  parameter int GUARD = 8
) (
  input  logic         clk,
  input  logic         reset,
  seg7_scan_if.slave   bus
);

  localparam logic [DIV_W-1:0] GUARD_C = DIV_W'(GUARD);

  logic [DIV_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [27:0]      r_sh_d;
  logic [3:0]       r_sh_an;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;

  logic             w_load;
  logic             w_pwm_on;
  logic             w_lit;
  logic [6:0]       w_seg_sel;
  logic [3:0]       w_an_sel;

  assign w_load = (r_idx == 2'd0) && (r_cnt == '0);

`ifdef SEG7_BRIGHTNESS_EN
  assign w_pwm_on = (r_cnt[3:0] <= bus.bright);
`else
  assign w_pwm_on = 1'b1;
`endif

  // The load-cycle state always falls inside the guard window, so the stale
  // pre-load shadow is never shown.
  assign w_lit = (r_cnt >= GUARD_C) && !r_sh_an[r_idx] && w_pwm_on;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_seg_sel = 7'h7F;
    w_an_sel  = 4'hF;
    case (r_idx)
      2'd0: begin w_seg_sel = r_sh_d[6:0];   w_an_sel = 4'b1110; end
      2'd1: begin w_seg_sel = r_sh_d[13:7];  w_an_sel = 4'b1101; end
      2'd2: begin w_seg_sel = r_sh_d[20:14]; w_an_sel = 4'b1011; end
      2'd3: begin w_seg_sel = r_sh_d[27:21]; w_an_sel = 4'b0111; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_sh_d  <= 28'hFFFFFFF;
      r_sh_an <= 4'hF;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
      if (r_cnt == '1)
        r_idx <= r_idx + 2'd1;
      if (w_load) begin
        r_sh_d  <= bus.D_in;
        r_sh_an <= bus.AN_in;
      end
      r_an  <= w_lit ? w_an_sel  : 4'hF;
      r_seg <= w_lit ? w_seg_sel : 7'h7F;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.an          = r_an;
  assign bus.frame_start = w_load;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at DIV_W=4, GUARD=2 (16-cycle slot, 64-cycle frame).
// Brightness cases run only when SEG7_BRIGHTNESS_EN is defined.
module tb_seg7_scan_driver;
  localparam int DIV_W = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = 1 << DIV_W;
  localparam int FRAME = 4 * SLOT;

  localparam logic [27:0] PAT = {7'h30, 7'h24, 7'h79, 7'h40};

  logic clk = 1'b0;
  logic reset;
  seg7_scan_if bus();

  seg7_scan_driver #(.DIV_W(DIV_W), .GUARD(GUARD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Spec-level model state (values held before the next edge).
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [27:0] m_sh_d  = 28'hFFFFFFF;
  logic [3:0]  m_sh_an = 4'hF;
  logic [3:0]  m_bright = 4'hF;

  int          lit_cnt [4];
  logic [6:0]  lit_seg [4];
  int          fs_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the outputs after the coming edge, push them, clock, then pop and compare.
  task automatic tick();
    exp_t e;
    exp_t g;
    logic lit;
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_sh_d = 28'hFFFFFFF; m_sh_an = 4'hF;
      e.an = 4'hF; e.seg = 7'h7F;
    end else begin
      lit  = (m_cnt >= GUARD) && !m_sh_an[m_idx] && ((m_cnt % 16) <= int'(m_bright));
      e.an  = lit ? ~(4'b0001 << m_idx) : 4'hF;
      e.seg = lit ? m_sh_d[7*m_idx +: 7] : 7'h7F;
      if (m_idx == 0 && m_cnt == 0) begin
        m_sh_d  = bus.D_in;
        m_sh_an = bus.AN_in;
      end
      if (m_cnt == SLOT - 1) m_idx = (m_idx + 1) % 4;
      m_cnt = (m_cnt + 1) % SLOT;
    end
    e.fs = (m_idx == 0 && m_cnt == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("an",          {28'd0, bus.an},          {28'd0, g.an});
    check("seg",         {25'd0, bus.seg},         {25'd0, g.seg});
    check("frame_start", {31'd0, bus.frame_start}, {31'd0, g.fs});
    check("an_onehot",   {31'd0, ($countones(~bus.an) <= 1)}, 32'd1);
    for (int k = 0; k < 4; k++)
      if (bus.an == ~(4'b0001 << k)) begin
        lit_cnt[k]++;
        lit_seg[k] = bus.seg;
      end
    if (bus.frame_start) fs_cnt++;
  endtask

  // Run one frame starting in the load state; optionally change D_in mid-frame.
  task automatic run_frame(input int chg_at, input logic [27:0] chg_d);
    for (int k = 0; k < 4; k++) begin lit_cnt[k] = 0; lit_seg[k] = 7'h7F; end
    fs_cnt = 0;
    for (int t = 1; t <= FRAME; t++) begin
      if (t == chg_at) bus.D_in = chg_d;
      tick();
    end
    check("fs_once_per_frame", fs_cnt, 1);
    check("fs_at_frame_end", {31'd0, bus.frame_start}, 32'd1);
  endtask

  task automatic expect_frame(input string tag, input int lit_exp [4], input logic [6:0] seg_exp [4]);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_lit%0d", tag, k), lit_cnt[k], lit_exp[k]);
      if (lit_exp[k] != 0)
        check($sformatf("%s_seg%0d", tag, k), {25'd0, lit_seg[k]}, {25'd0, seg_exp[k]});
    end
  endtask

  int         full [4]  = '{14, 14, 14, 14};
  int         half [4]  = '{14, 14, 0, 0};
  logic [6:0] pat_s [4] = '{7'h40, 7'h79, 7'h24, 7'h30};
  logic [6:0] zero_s [4] = '{7'h00, 7'h00, 7'h00, 7'h00};

  initial begin
    bus.D_in  = PAT;
    bus.AN_in = 4'h0;
`ifdef SEG7_BRIGHTNESS_EN
    bus.bright = 4'hF;
`endif
    // Test 1: reset held 3 cycles, then frame_start on release.
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("reset_an",  {28'd0, bus.an},  32'hF);
      check("reset_seg", {25'd0, bus.seg}, 32'h7F);
    end
    reset = 1'b0;
    check("fs_first_after_release", {31'd0, bus.frame_start}, 32'd1);

    // Test 2: four digits lit 14 cycles each in slot order.
    run_frame(0, '0);
    expect_frame("t2", full, pat_s);

    // Test 3: digits 2 and 3 blanked.
    bus.AN_in = 4'b1100;
    run_frame(0, '0);
    expect_frame("t3", half, pat_s);

    // Test 4: D_in changes during slot 1; visible only in the following frame.
    bus.AN_in = 4'h0;
    run_frame(SLOT + 4, 28'h0);
    expect_frame("t4_old", full, pat_s);
    run_frame(0, '0);
    expect_frame("t4_new", full, zero_s);

    // Test 5: one-cycle reset in slot 2 at cnt 7.
    bus.D_in = PAT;
    for (int t = 0; t < 2 * FRAME && !(m_idx == 2 && m_cnt == 7); t++) tick();
    check("reach_slot2_cnt7", {31'd0, (m_idx == 2 && m_cnt == 7)}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_reset_an",  {28'd0, bus.an},  32'hF);
    check("t5_reset_seg", {25'd0, bus.seg}, 32'h7F);
    check("t5_fs",        {31'd0, bus.frame_start}, 32'd1);
    run_frame(0, '0);
    expect_frame("t5", full, pat_s);

`ifdef SEG7_BRIGHTNESS_EN
    // Test 6: PWM duty.
    begin
      int two [4] = '{2, 2, 2, 2};
      bus.bright = 4'd3; m_bright = 4'd3;
      run_frame(0, '0);
      expect_frame("t6_b3", two, pat_s);
      bus.bright = 4'hF; m_bright = 4'hF;
      run_frame(0, '0);
      expect_frame("t6_b15", full, pat_s);
    end
`endif

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
